// File: rtl/gba_mem_ctrl.sv
// GBA memory controller: decodes the CPU request, routes it to the 32-bit fast port or 16-bit wait-stated slow port.
// Optional WAITCNT register (ROM wait configuration at 0x04000204) is built in when GBA_WAITCNT_EN is defined.
module gba_mem_ctrl #(
    parameter int unsigned EWRAM_WAIT = 2,
    parameter int unsigned ROM_WAIT_N = 4,
    parameter int unsigned ROM_WAIT_S = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic [1:0]  mem_width,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_ok,
    output logic [29:0] fast_addr,
    output logic [3:0]  fast_be,
    output logic [31:0] fast_wdata,
    output logic        fast_re,
    output logic        fast_we,
    input  logic [31:0] fast_rdata,
    output logic [26:0] slow_addr,
    output logic [1:0]  slow_be,
    output logic [15:0] slow_wdata,
    output logic        slow_re,
    output logic        slow_we,
    input  logic [15:0] slow_rdata
);

    localparam int CW = 8;

    typedef enum logic [2:0] {S_IDLE, S_FAST, S_BEAT0, S_BEAT1, S_RESP} state_t;
    typedef enum logic [1:0] {SRC_FAST, SRC_SLOW, SRC_UNMAP, SRC_WCNT} src_t;

    state_t          state_q;
    src_t            src_q;
    logic [CW-1:0]   cnt_q;
    logic [27:0]     addr_q;
    logic [1:0]      width_q;
    logic            write_q;
    logic            rom_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;

    src_t            dec_src;
    logic            dec_rom;
    logic            req;
    logic            is_wr;
    logic            fast_act;
    logic            in_beat;
    logic            beat1;
    logic [CW-1:0]   ewram_wait;
    logic [CW-1:0]   rom_wait_n;
    logic [CW-1:0]   rom_wait_s;
    logic [31:0]     rd_val;

`ifdef GBA_WAITCNT_EN
    localparam logic [31:0] WAITCNT_ADDR = 32'h0400_0204;
    logic [15:0] waitcnt_q;

    always_comb begin
        case (waitcnt_q[3:2])
            2'd0:    rom_wait_n = CW'(4);
            2'd1:    rom_wait_n = CW'(3);
            2'd2:    rom_wait_n = CW'(2);
            default: rom_wait_n = CW'(8);
        endcase
        rom_wait_s = waitcnt_q[4] ? CW'(1) : CW'(2);
    end
`else
    assign rom_wait_n = CW'(ROM_WAIT_N);
    assign rom_wait_s = CW'(ROM_WAIT_S);
`endif

    assign ewram_wait = CW'(EWRAM_WAIT);

    function automatic logic [31:0] lane_sel(input logic [31:0] d, input logic [1:0] w,
                                             input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (w[1]) begin
            r = d;
        end else if (w[0]) begin
            r = {16'h0, a[1] ? d[31:16] : d[15:0]};
        end else begin
            case (a)
                2'd0:    r = {24'h0, d[7:0]};
                2'd1:    r = {24'h0, d[15:8]};
                2'd2:    r = {24'h0, d[23:16]};
                default: r = {24'h0, d[31:24]};
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] be4(input logic [1:0] w, input logic [1:0] a);
        logic [3:0] r;
        if (w[1])      r = 4'b1111;
        else if (w[0]) r = a[1] ? 4'b1100 : 4'b0011;
        else           r = 4'b0001 << a;
        return r;
    endfunction

    function automatic logic [31:0] repl32(input logic [31:0] d, input logic [1:0] w);
        logic [31:0] r;
        if (w[1])      r = d;
        else if (w[0]) r = {2{d[15:0]}};
        else           r = {4{d[7:0]}};
        return r;
    endfunction

    always_comb begin
        dec_src = SRC_UNMAP;
        dec_rom = 1'b0;
        case (mem_addr[27:24])
            4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: dec_src = SRC_FAST;
            4'h2: dec_src = SRC_SLOW;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                dec_src = SRC_SLOW;
                dec_rom = 1'b1;
            end
            default: dec_src = SRC_UNMAP;
        endcase
`ifdef GBA_WAITCNT_EN
        if (mem_addr == WAITCNT_ADDR) dec_src = SRC_WCNT;
`endif
    end

    // Reads win if the CPU ever raises both strobes.
    assign is_wr = mem_write & ~mem_read;
    assign req   = (mem_read | mem_write) & (state_q == S_IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= SRC_UNMAP;
            cnt_q   <= '0;
            addr_q  <= '0;
            width_q <= '0;
            write_q <= 1'b0;
            rom_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef GBA_WAITCNT_EN
            waitcnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_addr[27:0];
                        width_q <= mem_width;
                        write_q <= is_wr;
                        wdata_q <= mem_data;
                        src_q   <= dec_src;
                        rom_q   <= dec_rom;
                        rdata_q <= '0;
                        if (dec_src == SRC_SLOW) begin
                            state_q <= S_BEAT0;
                            cnt_q   <= dec_rom ? rom_wait_n : ewram_wait;
                        end else begin
                            state_q <= S_RESP;
                        end
`ifdef GBA_WAITCNT_EN
                        if (dec_src == SRC_WCNT && is_wr) begin
                            if (mem_width == 2'd0) waitcnt_q[7:0] <= mem_data[7:0];
                            else                   waitcnt_q      <= mem_data[15:0];
                        end
`endif
                    end
                end
                S_FAST: state_q <= S_RESP;
                S_BEAT0: begin
                    if (cnt_q == '0) begin
                        rdata_q[15:0] <= slow_rdata;
                        if (width_q[1]) begin
                            state_q <= S_BEAT1;
                            cnt_q   <= rom_q ? rom_wait_s : ewram_wait;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_BEAT1: begin
                    if (cnt_q == '0) begin
                        rdata_q[31:16] <= slow_rdata;
                        state_q        <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Fast port is strobed combinationally in the accept cycle so read data lands in RESP.
    assign fast_act   = req & (dec_src == SRC_FAST);
    assign fast_re    = fast_act & mem_read;
    assign fast_we    = fast_act & is_wr;
    assign fast_addr  = fast_act ? mem_addr[31:2] : '0;
    assign fast_be    = fast_act ? be4(mem_width, mem_addr[1:0]) : '0;
    assign fast_wdata = fast_act ? repl32(mem_data, mem_width) : '0;

    assign in_beat = (state_q == S_BEAT0) | (state_q == S_BEAT1);
    assign beat1   = (state_q == S_BEAT1);

    // ROM writes still walk the beats for timing but never strobe the bus.
    always_comb begin
        slow_re    = in_beat & ~write_q;
        slow_we    = in_beat & write_q & ~rom_q;
        slow_addr  = '0;
        slow_be    = '0;
        slow_wdata = '0;
        if (in_beat) begin
            if (width_q[1]) begin
                slow_addr  = {addr_q[27:2], beat1};
                slow_be    = 2'b11;
                slow_wdata = beat1 ? wdata_q[31:16] : wdata_q[15:0];
            end else if (width_q[0]) begin
                slow_addr  = addr_q[27:1];
                slow_be    = 2'b11;
                slow_wdata = wdata_q[15:0];
            end else begin
                slow_addr  = addr_q[27:1];
                slow_be    = addr_q[0] ? 2'b10 : 2'b01;
                slow_wdata = {2{wdata_q[7:0]}};
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (src_q)
            SRC_FAST: rd_val = lane_sel(fast_rdata, width_q, addr_q[1:0]);
            SRC_SLOW: begin
                if (width_q[1])      rd_val = rdata_q;
                else if (width_q[0]) rd_val = {16'h0, rdata_q[15:0]};
                else                 rd_val = {24'h0, addr_q[0] ? rdata_q[15:8] : rdata_q[7:0]};
            end
`ifdef GBA_WAITCNT_EN
            SRC_WCNT: rd_val = (width_q == 2'd0) ? {24'h0, waitcnt_q[7:0]} : {16'h0, waitcnt_q};
`endif
            default:  rd_val = '0;
        endcase
    end

    assign mem_ok   = (state_q == S_RESP);
    assign mem_data = (mem_ok && mem_read) ? rd_val : 32'bz;

endmodule

// File: tb/tb_gba_mem_ctrl.sv
// Directed bench for gba_mem_ctrl (default build, GBA_WAITCNT_EN undefined).
module tb_gba_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ok;
    logic [29:0] fast_addr;
    logic [3:0]  fast_be;
    logic [31:0] fast_wdata;
    logic        fast_re;
    logic        fast_we;
    logic [31:0] fast_rdata;
    logic [26:0] slow_addr;
    logic [1:0]  slow_be;
    logic [15:0] slow_wdata;
    logic        slow_re;
    logic        slow_we;
    logic [15:0] slow_rdata;

    logic        drv_en;
    logic [31:0] drv_val;
    logic [15:0] slow_lo;
    logic [15:0] slow_hi;

    int          n_cmp;
    int          n_mis;

    logic        r_fre0, r_fwe0;
    logic [29:0] r_faddr0;
    logic [3:0]  r_fbe0;
    logic [31:0] r_fwd0;
    int          n_sre, n_swe;
    logic [26:0] r_saddr_first, r_saddr_last;
    logic [1:0]  r_sbe_first;
    logic [15:0] r_swd_first, r_swd_last;

    int          okc;
    logic [31:0] dat;
    int          cnt;

    assign mem_data   = drv_en ? drv_val : 32'bz;
    assign slow_rdata = slow_addr[0] ? slow_hi : slow_lo;

    gba_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_width  (mem_width),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_ok     (mem_ok),
        .fast_addr  (fast_addr),
        .fast_be    (fast_be),
        .fast_wdata (fast_wdata),
        .fast_re    (fast_re),
        .fast_we    (fast_we),
        .fast_rdata (fast_rdata),
        .slow_addr  (slow_addr),
        .slow_be    (slow_be),
        .slow_wdata (slow_wdata),
        .slow_re    (slow_re),
        .slow_we    (slow_we),
        .slow_rdata (slow_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at posedge+1 (cycle 0) and hold it until mem_ok.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [1:0] w, input logic [31:0] wd,
                          output int ok_cycle, output logic [31:0] rdat);
        mem_addr  = a;
        mem_width = w;
        mem_read  = rd;
        mem_write = wr;
        drv_en    = wr;
        drv_val   = wd;
        ok_cycle  = -1;
        rdat      = 32'h0;
        n_sre = 0;
        n_swe = 0;
        r_saddr_first = '0;
        r_saddr_last  = '0;
        r_sbe_first   = '0;
        r_swd_first   = '0;
        r_swd_last    = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                r_fre0   = fast_re;
                r_fwe0   = fast_we;
                r_faddr0 = fast_addr;
                r_fbe0   = fast_be;
                r_fwd0   = fast_wdata;
            end
            if (slow_re || slow_we) begin
                if (n_sre + n_swe == 0) begin
                    r_saddr_first = slow_addr;
                    r_sbe_first   = slow_be;
                    r_swd_first   = slow_wdata;
                end
                r_saddr_last = slow_addr;
                r_swd_last   = slow_wdata;
                if (slow_re) n_sre++;
                if (slow_we) n_swe++;
            end
            if (mem_ok) begin
                ok_cycle = c;
                rdat     = mem_data;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok_cycle >= 0) begin
            @(posedge clk);
            #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        drv_en    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst        = 1'b1;
        mem_addr   = 32'h0300_0000;
        mem_width  = 2'd2;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        drv_en     = 1'b0;
        drv_val    = 32'h0;
        fast_rdata = 32'h0;
        slow_lo    = 16'h0;
        slow_hi    = 16'h0;

        // Reset state with a request pending on the bus
        repeat (2) @(negedge clk);
        chk("rst_mem_ok", {31'h0, mem_ok}, 32'h0);
        chk("rst_fast_re", {31'h0, fast_re}, 32'h0);
        chk("rst_fast_be", {28'h0, fast_be}, 32'h0);
        chk("rst_slow_strobes", {30'h0, slow_re, slow_we}, 32'h0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fast word read
        fast_rdata = 32'hDEAD_BEEF;
        access(1'b1, 1'b0, 32'h0300_0010, 2'd2, 32'h0, okc, dat);
        chk("fw_rd_re0", {31'h0, r_fre0}, 32'h1);
        chk("fw_rd_addr", {2'b0, r_faddr0}, 32'h00C0_0004);
        chk("fw_rd_be", {28'h0, r_fbe0}, 32'hF);
        chk("fw_rd_okc", 32'(okc), 32'd1);
        chk("fw_rd_data", dat, 32'hDEAD_BEEF);

        // EWRAM byte write
        access(1'b0, 1'b1, 32'h0200_0003, 2'd0, 32'h0000_005A, okc, dat);
        chk("ew_bw_be", {30'h0, r_sbe_first}, 32'h2);
        chk("ew_bw_wdata", {16'h0, r_swd_first}, 32'h5A5A);
        chk("ew_bw_we_cycles", 32'(n_swe), 32'd3);
        chk("ew_bw_re_cycles", 32'(n_sre), 32'd0);
        chk("ew_bw_okc", 32'(okc), 32'd4);

        // ROM word read, default waits
        slow_lo = 16'h1234;
        slow_hi = 16'hABCD;
        access(1'b1, 1'b0, 32'h0800_0000, 2'd2, 32'h0, okc, dat);
        chk("rom_wr_okc", 32'(okc), 32'd9);
        chk("rom_wr_data", dat, 32'hABCD_1234);
        chk("rom_wr_addr0", {5'h0, r_saddr_first}, 32'h0400_0000);
        chk("rom_wr_addr1", {5'h0, r_saddr_last}, 32'h0400_0001);
        chk("rom_wr_re_cycles", 32'(n_sre), 32'd8);

        // Fast byte read lane 2
        fast_rdata = 32'h1122_3344;
        access(1'b1, 1'b0, 32'h0600_0002, 2'd0, 32'h0, okc, dat);
        chk("fb_rd_be", {28'h0, r_fbe0}, 32'h4);
        chk("fb_rd_data", dat, 32'h0000_0022);

        // Fast halfword write, upper lane
        access(1'b0, 1'b1, 32'h0400_0006, 2'd1, 32'h0000_BEEF, okc, dat);
        chk("fh_wr_we0", {31'h0, r_fwe0}, 32'h1);
        chk("fh_wr_be", {28'h0, r_fbe0}, 32'hC);
        chk("fh_wr_wdata", r_fwd0, 32'hBEEF_BEEF);
        chk("fh_wr_okc", 32'(okc), 32'd1);

        // EWRAM halfword read at odd halfword address
        slow_lo = 16'h1111;
        slow_hi = 16'h5678;
        access(1'b1, 1'b0, 32'h0200_0102, 2'd1, 32'h0, okc, dat);
        chk("ew_hr_okc", 32'(okc), 32'd4);
        chk("ew_hr_data", dat, 32'h0000_5678);
        chk("ew_hr_addr", {5'h0, r_saddr_first}, 32'h0100_0081);

        // EWRAM word write: two beats
        access(1'b0, 1'b1, 32'h0200_0010, 2'd2, 32'hCAFE_F00D, okc, dat);
        chk("ew_ww_okc", 32'(okc), 32'd7);
        chk("ew_ww_lo", {16'h0, r_swd_first}, 32'h0000_F00D);
        chk("ew_ww_hi", {16'h0, r_swd_last}, 32'h0000_CAFE);
        chk("ew_ww_be", {30'h0, r_sbe_first}, 32'h3);
        chk("ew_ww_we_cycles", 32'(n_swe), 32'd6);

        // ROM write is acknowledged but never strobed
        access(1'b0, 1'b1, 32'h0800_0010, 2'd1, 32'h0000_1357, okc, dat);
        chk("rom_hw_we_cycles", 32'(n_swe), 32'd0);
        chk("rom_hw_okc", 32'(okc), 32'd6);

        // ROM byte read, odd byte
        slow_lo = 16'h9A7B;
        slow_hi = 16'h0000;
        access(1'b1, 1'b0, 32'h0800_0005, 2'd0, 32'h0, okc, dat);
        chk("rom_br_okc", 32'(okc), 32'd6);
        chk("rom_br_data", dat, 32'h0000_009A);

        // Unmapped write: quick ack, no strobes
        access(1'b0, 1'b1, 32'h0100_0000, 2'd2, 32'h1234_5678, okc, dat);
        chk("um_wr_okc", 32'(okc), 32'd1);
        chk("um_wr_fwe", {31'h0, r_fwe0}, 32'h0);

        // Reset during BEAT0 of a ROM read
        slow_lo = 16'h4444;
        mem_addr  = 32'h0800_0000;
        mem_width = 2'd2;
        mem_read  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_pre_re", {31'h0, slow_re}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_re", {31'h0, slow_re}, 32'h0);
        chk("mid_rst_ok", {31'h0, mem_ok}, 32'h0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_ok) cnt++;
        end
        chk("mid_no_ok", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h0E00_0000, 2'd2, 32'h0, okc, dat);
        chk("um_rd_okc", 32'(okc), 32'd1);
        chk("um_rd_data", dat, 32'h0);

        // Back-to-back: held request completes every other cycle
        fast_rdata = 32'h0;
        mem_addr   = 32'h0300_0000;
        mem_width  = 2'd2;
        mem_read   = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_ok) cnt++;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        chk("b2b_ok_count", 32'(cnt), 32'd3);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
